// File: rtl/bist_pkg.sv
// Shared state encodings and counter widths for the BIST signature controller.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_APPLY   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

  localparam int unsigned PAT_CNT_W   = 16;
  localparam int unsigned DRAIN_CNT_W = 4;

  function automatic logic is_busy(input bist_state_t s);
    return s inside {ST_CLEAR, ST_APPLY, ST_DRAIN, ST_COMPARE};
  endfunction

endpackage

// File: rtl/bist_pat_counter.sv
// Loadable up/down counter with a terminal-count flag.
module bist_pat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_inc)  r_count <= r_count + 1'b1;
    else if (i_dec)  r_count <= r_count - 1'b1;
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_tc_val);

endmodule

// File: rtl/bist_sig_controller.sv
// BIST sequencer: clear MISR, apply patterns, drain pipeline, compare signature.
module bist_sig_controller
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       NUM_PATTERNS = 255,
  parameter int unsigned       PIPE_LAT     = 1,
  parameter logic [WIDTH-1:0]  GOLDEN       = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     sig_in,
  output logic                 misr_clr,
  output logic                 misr_en,
  output logic                 tpg_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WIDTH-1:0]     signature,
  output logic [PAT_CNT_W-1:0] pat_cnt
);

  bist_state_t            r_state;
  bist_state_t            w_next;
  logic                   w_pat_load;
  logic                   w_pat_inc;
  logic                   w_pat_tc;
  logic [PAT_CNT_W-1:0]   w_pat_cnt;
  logic                   w_drn_load;
  logic                   w_drn_dec;
  logic                   w_drn_tc;
  logic [DRAIN_CNT_W-1:0] w_drn_cnt;
  logic [WIDTH-1:0]       r_signature;
  logic                   r_pass;

  bist_pat_counter #(.W(PAT_CNT_W)) u_pat_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_pat_load),
    .i_load_val ('0),
    .i_inc      (w_pat_inc),
    .i_dec      (1'b0),
    .i_tc_val   (PAT_CNT_W'(NUM_PATTERNS - 1)),
    .o_count    (w_pat_cnt),
    .o_tc       (w_pat_tc)
  );

  bist_pat_counter #(.W(DRAIN_CNT_W)) u_drn_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_drn_load),
    .i_load_val (DRAIN_CNT_W'(PIPE_LAT)),
    .i_inc      (1'b0),
    .i_dec      (w_drn_dec),
    .i_tc_val   (DRAIN_CNT_W'(1)),
    .o_count    (w_drn_cnt),
    .o_tc       (w_drn_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // The APPLY cycle in which abort arrives still counts its pattern, since tpg_en was high.
  always_comb begin
    w_next     = r_state;
    w_pat_load = 1'b0;
    w_pat_inc  = 1'b0;
    w_drn_load = 1'b0;
    w_drn_dec  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CLEAR;
      ST_CLEAR: begin
        w_pat_load = 1'b1;
        w_next     = abort ? ST_IDLE : ST_APPLY;
      end
      ST_APPLY: begin
        w_pat_inc = 1'b1;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_pat_tc) begin
          w_drn_load = 1'b1;
          w_next     = (PIPE_LAT > 0) ? ST_DRAIN : ST_COMPARE;
        end
      end
      ST_DRAIN: begin
        w_drn_dec = 1'b1;
        if (abort)                             w_next = ST_IDLE;
        else if (w_drn_tc || w_drn_cnt == '0)  w_next = ST_COMPARE;
      end
      ST_COMPARE: w_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE:    if (start) w_next = ST_CLEAR;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_signature <= '0;
      r_pass      <= 1'b0;
    end else if (r_state == ST_COMPARE && !abort) begin
      r_signature <= sig_in;
      r_pass      <= (sig_in == GOLDEN);
    end else if (w_next != ST_DONE) begin
      r_pass      <= 1'b0;
    end
  end

  assign misr_clr  = (r_state == ST_CLEAR);
  assign tpg_en    = (r_state == ST_APPLY);
  assign misr_en   = (r_state == ST_APPLY) || (r_state == ST_DRAIN);
  assign busy      = is_busy(r_state);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign signature = r_signature;
  assign pat_cnt   = w_pat_cnt;

endmodule
